// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: FSM encoding,
// decoder op encoding and the iteration-counter sizing helper.
package mcycle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } mc_state_e;

  localparam logic MC_MUL = 1'b0;
  localparam logic MC_DIV = 1'b1;

  // Bits needed to count 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) unit that
// stalls the pipeline via Busy and pulses Done with a registered result pair.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mc_state_e          state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   result1_q, result1_d;
  logic [WIDTH-1:0]   result2_q, result2_d;

  logic [2*WIDTH:0]   acc_step;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH:0]     rem_next;
  logic               rem_ge;

  // One iteration of the selected algorithm. The accumulator holds the
  // partial product / partial remainder in its upper WIDTH+1 bits and the
  // multiplier / dividend-then-quotient in its lower WIDTH bits.
  always_comb begin
    mul_sum   = acc_q[2*WIDTH:WIDTH] + {1'b0, addend_q};
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, addend_q};
    rem_ge    = (rem_shift >= {1'b0, addend_q});
    rem_next  = rem_ge ? rem_diff : rem_shift;
    acc_step  = acc_q;
    if (op_q == MC_MUL) begin
      if (acc_q[0]) begin
        acc_step = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
      end else begin
        acc_step = {1'b0, acc_q[2*WIDTH:1]};
      end
    end else begin
      acc_step = {rem_next, acc_q[WIDTH-2:0], rem_ge};
    end
  end

  // Next-state and register-update logic for the IDLE/COMPUTE/DONE sequence.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addend_d  = addend_q;
    acc_d     = acc_q;
    count_d   = count_q;
    result1_d = result1_q;
    result2_d = result2_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = COMPUTE;
          op_d     = MCycleOp;
          addend_d = (MCycleOp == MC_MUL) ? Operand1 : Operand2;
          acc_d    = {{(WIDTH+1){1'b0}}, (MCycleOp == MC_MUL) ? Operand2 : Operand1};
          count_d  = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        acc_d   = acc_step;
        count_d = count_q + CW'(1);
        if (count_q == LAST_CNT) begin
          state_d   = DONE;
          result1_d = acc_step[WIDTH-1:0];
          result2_d = acc_step[2*WIDTH-1:WIDTH];
        end else begin
          state_d = COMPUTE;
        end
      end
      // Start still high here belongs to the finishing instruction.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers; reset aborts any operation.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      addend_q  <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH+1){1'b0}};
      count_q   <= {CW{1'b0}};
      result1_q <= {WIDTH{1'b0}};
      result2_q <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addend_q  <= addend_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  assign Result1 = result1_q;
  assign Result2 = result2_q;
  assign Done    = (state_q == DONE);
  assign Busy    = ((state_q == IDLE) && Start) || (state_q == COMPUTE);

endmodule
